alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 61 ++++++
 rtl/alu_sequencer_if.sv | 50 +++++
 rtl/alu_sequencer_lut.sv | 31 +++
 rtl/alu_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : alu_sequencer_pkg
// Brief    : Opcode constants, opcode-to-hold-count table and sequencer state
//            encoding shared by the ALU and its sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package alu_sequencer_pkg;

   // Width of the hold counter (base hold plus EXTRA_HOLD must fit)
   localparam int unsigned c_hold_w = 8;

   localparam logic [5:0] c_op_add   = 6'b100000;
   localparam logic [5:0] c_op_sub   = 6'b100001;
   localparam logic [5:0] c_op_mul   = 6'b100010;
   localparam logic [5:0] c_op_div   = 6'b100011;
   localparam logic [5:0] c_op_mod   = 6'b100101;
   localparam logic [5:0] c_op_incdc = 6'b100100;
   localparam logic [5:0] c_op_cmp   = 6'b010110;
   localparam logic [5:0] c_op_and   = 6'b010010;
   localparam logic [5:0] c_op_or    = 6'b010011;
   localparam logic [5:0] c_op_xor   = 6'b010100;
   localparam logic [5:0] c_op_not   = 6'b010101;
   localparam logic [5:0] c_op_shrot = 6'b010000;
   localparam logic [5:0] c_op_frld  = 6'b000110;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      SETTLE = 3'd2,
      RESP   = 3'd3,
      DRAIN  = 3'd4
   } seq_state_t;

   // ALU stage count + 1 for each opcode; zero marks an illegal opcode
   function automatic logic [3:0] base_hold(input logic [5:0] opcode);
      case (opcode)
         c_op_add:   base_hold = 4'd3;
         c_op_sub:   base_hold = 4'd4;
         c_op_mul:   base_hold = 4'd3;
         c_op_div:   base_hold = 4'd3;
         c_op_mod:   base_hold = 4'd3;
         c_op_incdc: base_hold = 4'd2;
         c_op_cmp:   base_hold = 4'd2;
         c_op_and:   base_hold = 4'd3;
         c_op_or:    base_hold = 4'd3;
         c_op_xor:   base_hold = 4'd3;
         c_op_not:   base_hold = 4'd3;
         c_op_shrot: base_hold = 4'd2;
         c_op_frld:  base_hold = 4'd2;
         default:    base_hold = 4'd0;
      endcase
   endfunction

   // Ops whose only useful product is the flag register
   function automatic logic flags_only(input logic [5:0] opcode);
      flags_only = (opcode == c_op_cmp) || (opcode == c_op_frld);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface : alu_sequencer_if
// Brief     : Request/response handshake plus the ALU-side bus of the
//             sequencer. slave = sequencer view, master = client/ALU view.
// Revision  : 1.0 - initial release
// ============================================================================
interface alu_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  req_opcode;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [15:0] req_fr;
   logic        req_use_carry;
   logic        req_dec;
   logic [2:0]  req_shift;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_result;
   logic [15:0] rsp_fr;
   logic        rsp_err;

   logic        enable_alu;
   logic [5:0]  opCode;
   logic [15:0] m3;
   logic [15:0] m4;
   logic [15:0] FR_in;
   logic        useCarry;
   logic        dec;
   logic [2:0]  flagToShifthAndRot;
   logic [15:0] m2;
   logic [15:0] FR_out;

   modport slave (
      input  req_valid, req_opcode, req_a, req_b, req_fr, req_use_carry,
             req_dec, req_shift, rsp_ready, m2, FR_out,
      output req_ready, rsp_valid, rsp_result, rsp_fr, rsp_err, enable_alu,
             opCode, m3, m4, FR_in, useCarry, dec, flagToShifthAndRot
   );

   modport master (
      output req_valid, req_opcode, req_a, req_b, req_fr, req_use_carry,
             req_dec, req_shift, rsp_ready, m2, FR_out,
      input  req_ready, rsp_valid, rsp_result, rsp_fr, rsp_err, enable_alu,
             opCode, m3, m4, FR_in, useCarry, dec, flagToShifthAndRot
   );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer_lut.sv
`default_nettype none
// ============================================================================
// Module   : alu_latency_lut
// Brief    : Maps an opcode to its enable_alu hold count and a legal flag.
// Revision : 1.0 - initial release
// ============================================================================
module alu_latency_lut
   import alu_sequencer_pkg::*;
#(
   parameter int unsigned EXTRA_HOLD = 0
)
(
   input  logic [5:0]          i_opcode,
   output logic [c_hold_w-1:0] o_hold_n,
   output logic                o_legal
);

   logic [3:0] w_base;

   // Table lookup, then stretch legal ops by the configured extra hold
   always_comb begin
      w_base   = base_hold(i_opcode);
      o_legal  = (w_base != 4'd0);
      o_hold_n = '0;
      if (o_legal) begin
         o_hold_n = {{(c_hold_w-4){1'b0}}, w_base} + c_hold_w'(EXTRA_HOLD);
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Brief    : Accepts one ALU request at a time, holds enable_alu for the op's
//            stage count, captures the ALU result and returns it. A reset that
//            lands mid-issue drains the ALU instead of abandoning it.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int unsigned EXTRA_HOLD = 0
)
(
   input  logic           wire_clock,
   input  logic           reset,
   alu_sequencer_if.slave bus
);

   localparam logic [c_hold_w-1:0] c_one = 1;

   seq_state_t          r_state;
   seq_state_t          w_state_nxt;
   logic [c_hold_w-1:0] r_cnt;
   logic [c_hold_w-1:0] w_cnt_nxt;
   logic [c_hold_w-1:0] w_hold_n;
   logic                w_legal;
   logic                r_enable;
   logic                w_enable_nxt;
   logic                w_accept;
   logic                w_load_alu;
   logic                w_clear_alu;
   logic                w_capture;
   logic                w_illegal_rsp;

   logic [5:0]          r_opcode;
   logic [15:0]         r_m3;
   logic [15:0]         r_m4;
   logic [15:0]         r_fr_in;
   logic                r_use_carry;
   logic                r_dec;
   logic [2:0]          r_shift;

   logic [15:0]         r_rsp_result;
   logic [15:0]         r_rsp_fr;
   logic                r_rsp_err;

   alu_latency_lut #(
      .EXTRA_HOLD (EXTRA_HOLD)
   ) u_lut (
      .i_opcode (bus.req_opcode),
      .o_hold_n (w_hold_n),
      .o_legal  (w_legal)
   );

   // Ready is also masked by reset so nothing is offered while reset is held
   assign bus.req_ready  = (r_state == IDLE) && !reset;
   assign w_accept       = bus.req_valid && bus.req_ready;

   assign bus.rsp_valid  = (r_state == RESP);
   assign bus.rsp_result = r_rsp_result;
   assign bus.rsp_fr     = r_rsp_fr;
   assign bus.rsp_err    = r_rsp_err;

   assign bus.enable_alu         = r_enable;
   assign bus.opCode             = r_opcode;
   assign bus.m3                 = r_m3;
   assign bus.m4                 = r_m4;
   assign bus.FR_in              = r_fr_in;
   assign bus.useCarry           = r_use_carry;
   assign bus.dec                = r_dec;
   assign bus.flagToShifthAndRot = r_shift;

   // Next-state logic. ISSUE spends its first cycle with enable low (operands
   // settle, ALU sees a clean rising enable), then r_cnt enable-high cycles.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_enable_nxt  = 1'b0;
      w_load_alu    = 1'b0;
      w_clear_alu   = 1'b0;
      w_capture     = 1'b0;
      w_illegal_rsp = 1'b0;
      if ((r_state == DRAIN) || ((r_state == ISSUE) && reset)) begin
         // Finish the remaining hold, give one enable-low cycle, then idle;
         // reset does not shorten this.
         if (r_cnt != '0) begin
            w_state_nxt  = DRAIN;
            w_cnt_nxt    = r_cnt - c_one;
            w_enable_nxt = 1'b1;
         end else if (r_enable) begin
            w_state_nxt  = DRAIN;
         end else begin
            w_state_nxt  = IDLE;
            w_clear_alu  = 1'b1;
         end
      end else if (reset) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
         w_clear_alu = 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_legal) begin
                     w_state_nxt = ISSUE;
                     w_cnt_nxt   = w_hold_n;
                     w_load_alu  = 1'b1;
                  end else begin
                     w_state_nxt   = RESP;
                     w_illegal_rsp = 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (r_cnt == '0) begin
                  w_state_nxt = SETTLE;
               end else begin
                  w_cnt_nxt    = r_cnt - c_one;
                  w_enable_nxt = 1'b1;
               end
            end
            SETTLE: begin
               w_state_nxt = RESP;
               w_capture   = 1'b1;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  w_state_nxt = IDLE;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_clear_alu = 1'b1;
            end
         endcase
      end
   end

   // State, hold counter and the registered ALU-side bus
   always_ff @(posedge wire_clock) begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_enable <= w_enable_nxt;
      if (w_clear_alu) begin
         r_opcode    <= '0;
         r_m3        <= '0;
         r_m4        <= '0;
         r_fr_in     <= '0;
         r_use_carry <= 1'b0;
         r_dec       <= 1'b0;
         r_shift     <= '0;
      end else if (w_load_alu) begin
         r_opcode    <= bus.req_opcode;
         r_m3        <= bus.req_a;
         r_m4        <= bus.req_b;
         r_fr_in     <= bus.req_fr;
         r_use_carry <= bus.req_use_carry;
         r_dec       <= bus.req_dec;
         r_shift     <= bus.req_shift;
      end
   end

   // Response payload: ALU capture at the end of SETTLE, or the illegal reply
   always_ff @(posedge wire_clock) begin
      if (reset) begin
         r_rsp_result <= '0;
         r_rsp_fr     <= '0;
         r_rsp_err    <= 1'b0;
      end else if (w_capture) begin
         r_rsp_result <= flags_only(r_opcode) ? 16'h0000 : bus.m2;
         r_rsp_fr     <= bus.FR_out;
         r_rsp_err    <= 1'b0;
      end else if (w_illegal_rsp) begin
         r_rsp_result <= 16'h0000;
         r_rsp_fr     <= bus.req_fr;
         r_rsp_err    <= 1'b1;
      end
   end

endmodule
`default_nettype wire
